serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial subtractor: computes DIFF = A - B one bit per clock, LSB first, by driving
//  one onebitfa cell with a, ~b and a carry register preset to 1 (two's complement).
//  Valid/ready handshakes sit on both the operand side and the result side.
//  Implementation sits beside the combinational adder in the arithmetic datapath.
//  It trades N cycles of latency for a single full-adder cell.
// PARAMETERS
//  WIDTH  8  operand and result width in bits; legal range 1..32.
// PORTS
//  clk        in   1      clock; all state changes on the rising edge.
//  rst_n      in   1      asynchronous, active-low reset.
//  in_valid   in   1      operands a/b are valid this cycle.
//  in_ready   out  1      block can accept operands this cycle.
//  a          in   WIDTH  minuend (unsigned, or two's complement).
//  b          in   WIDTH  subtrahend.
//  out_valid  out  1      diff, borrow and ovf are valid.
//  out_ready  in   1      consumer takes the result this cycle.
//  diff       out  WIDTH  a - b mod 2^WIDTH.
//  borrow     out  1      1 when unsigned a < b; equals ~final carry.
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB.
//  busy       out  1      high in SHIFT state.
// BEHAVIOUR
//  Reset (async assert, sync release) puts the block in IDLE and sets the outputs:
//    in_ready=1, out_valid=0, busy=0, diff=0, borrow=0, ovf=0.
//    Internal operand and carry registers are cleared.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//    - in_ready=1.
//    - If in_valid=1, latch a into opa and b into opb, set carry=1 and bit counter=0,
//      then go to SHIFT.
//  SHIFT (exactly WIDTH cycles):
//    - in_ready=0.
//    - Each edge computes fa(opa[0], ~opb[0], carry).
//    - sum shifts into diff from the MSB end; opa and opb shift right.
//    - carry <= cout; counter increments.
//    - On the edge where counter==WIDTH-1:
//        borrow <= ~cout, ovf <= carry ^ cout, then go to DONE.
//  DONE:
//    - out_valid=1; diff, borrow and ovf are held stable.
//    - If out_ready=1, go to IDLE, where out_valid=0 on the next cycle.
//    - If out_ready=0, hold indefinitely (backpressure).
//  Latency: operands accepted on edge k; out_valid is high after edge k+WIDTH.
//  Throughput: one result per WIDTH+2 cycles at best; in_ready=0 in the DONE cycle.
//  diff holds the last result until the next SHIFT overwrites it; it is not cleared at IDLE.
//  in_valid outside IDLE is ignored, and a/b may change freely there.
//  out_ready outside DONE is ignored.
//  rst_n low in any state, including mid-SHIFT, aborts the operation immediately.
//    No partial result is ever presented.
//  Counter width: $clog2(WIDTH)+1 bits, so WIDTH=1 works; that case is one SHIFT cycle.
//  Width rule: the result is exact modulo 2^WIDTH.
//    Unsigned reading: borrow is the bit-WIDTH underflow.
//    Signed reading: ovf flags an out-of-range result.
// STRUCTURE
//  Shared package (arith_pkg): state localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
//    A 2-bit state type is used for all serial arithmetic FSMs.
//  Sub-module: one instance of the existing onebitfa (a=opa[0], b=~opb[0], cin=carry).
//    No other arithmetic logic is used in this block.
//  Everything else is flops plus next-state logic in this file.
// TESTING
//  1) WIDTH=8, a=100, b=37 -> after 8 SHIFT cycles: diff=63, borrow=0, ovf=0.
//  2) a=5, b=9 -> diff=8'd252 (0xFC), borrow=1, ovf=0.
//  3) a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1; and a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1.
//  4) Hold out_ready=0 for 5 cycles in DONE.
//     -> out_valid stays 1, outputs stay stable, in_ready=0, and in_valid pulses are ignored.
//     Release out_ready -> IDLE on the next edge, in_ready=1.
//  5) Pull rst_n low on the 3rd SHIFT cycle.
//     -> outputs take reset values immediately.
//     Next op a=0, b=0 -> diff=0, borrow=0, with latency WIDTH.
//  6) WIDTH=1: a=0, b=1 -> one SHIFT cycle; diff=1, borrow=1, ovf=1.
//     Also run a randomized back-to-back sweep against the a-b reference model.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Every serial FSM in the datapath uses the same 2-bit state encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/onebitfa.sv
// Single-bit full adder cell.
// This is the only arithmetic element the serial blocks use.
module onebitfa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b, LSB first, using one full-adder cell fed with a and ~b.
// Valid/ready handshakes sit on the operand side and on the result side.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] diff_shifted;

  assign fa_b = ~opb_q[0];

  onebitfa u_fa (
    .a    (opa_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts the LSB lands at bit 0.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_shifted = fa_sum;
    end else begin : g_diff_wn
      assign diff_shifted = {fa_sum, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        diff_d  = diff_shifted;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // On the MSB cycle carry_q is the carry into the MSB, fa_cout the carry out of it.
        if (cnt_q == CW'(WIDTH - 1)) begin
          borrow_d = ~fa_cout;
          ovf_d    = carry_q ^ fa_cout;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule
